// File: rtl/p405s_timer_wdog_ctrl_pkg.sv
// Shared definitions for the timer/watchdog control block.
// Holds the TCR/TSR field positions (big-endian bit numbering) and the
// watchdog state encoding formed from the TSR {ENW, WIS} pair.
package p405s_timer_pkg;

    // TCR field start indices
    localparam int TCR_WP    = 0;   // [0:1] watchdog period select
    localparam int TCR_WRC   = 2;   // [2:3] watchdog reset control (sticky)
    localparam int TCR_WIE   = 4;   // watchdog interrupt enable
    localparam int TCR_PIE   = 5;   // PIT interrupt enable
    localparam int TCR_ARE   = 6;   // PIT auto-reload enable
    localparam int TCR_MIN_W = 7;

    // TSR bit indices
    localparam int TSR_ENW = 0;     // watchdog enable-next
    localparam int TSR_WIS = 1;     // watchdog interrupt status
    localparam int TSR_WRS = 2;     // [2:3] watchdog reset status
    localparam int TSR_PIS = 4;     // PIT interrupt status
    localparam int TSR_W   = 5;

    // Watchdog state is {ENW, WIS}
    typedef enum logic [1:0] {
        WD_IDLE = 2'b00,
        WD_WIS  = 2'b01,
        WD_ENW  = 2'b10,
        WD_EXP  = 2'b11
    } wdState_t;

    // Number of low counter bits that must be all ones for a watchdog event
    function automatic int wdPeriodBits(input int wdBase, input logic [1:0] wp);
        return wdBase + 4 * int'(wp);
    endfunction

endpackage

// File: rtl/p405s_timer_wdog_ctrl_if.sv
// SPR write bus as seen by the timer block: data, mtSPR qualifiers and the
// per-register decodes. The EXE/PCL side is the master.
interface p405s_timer_wdog_ctrl_if #(
    parameter int DW = 32
);

    logic [0:DW-1] EXE_sprDataBus;
    logic          PCL_mtSPR;
    logic          PCL_sprHold;
    logic          tcrDcd;
    logic          tsrDcd;
    logic          pitDcd;

    modport master (
        output EXE_sprDataBus,
        output PCL_mtSPR,
        output PCL_sprHold,
        output tcrDcd,
        output tsrDcd,
        output pitDcd
    );

    modport slave (
        input EXE_sprDataBus,
        input PCL_mtSPR,
        input PCL_sprHold,
        input tcrDcd,
        input tsrDcd,
        input pitDcd
    );

endinterface

// File: rtl/p405s_timer_wdog_ctrl_pit_dec.sv
// Programmable interval timer: down-counter plus reload register.
// A write always beats a tick in the same cycle. When the count passes
// through 1 on a tick, pisSet pulses and the count reloads (ARE=1) or stops.
module p405s_pit_dec #(
    parameter int PIT_W = 32
) (
    input  logic             CB,
    input  logic             resetCore,
    input  logic             wrPit,
    input  logic [0:PIT_W-1] wrData,
    input  logic             timerTick,
    input  logic             autoReload,
    output logic [0:PIT_W-1] pitCount,
    output logic             pisSet
);

    localparam logic [0:PIT_W-1] PIT_ONE = PIT_W'(1);

    logic [0:PIT_W-1] reloadVal;
    logic             pitAtOne;

    assign pitAtOne = (pitCount == PIT_ONE);
    assign pisSet   = timerTick & ~wrPit & pitAtOne;

    // Reload register only follows software writes to the PIT
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            reloadVal <= '0;
        end else if (wrPit) begin
            reloadVal <= wrData;
        end
    end

    // Count: write wins over tick; 1 -> reload/stop; 0 holds
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            pitCount <= '0;
        end else if (wrPit) begin
            pitCount <= wrData;
        end else if (timerTick) begin
            if (pitAtOne) begin
                pitCount <= autoReload ? reloadVal : '0;
            end else if (pitCount != '0) begin
                pitCount <= pitCount - PIT_ONE;
            end
        end
    end

endmodule

// File: rtl/p405s_timer_wdog_ctrl.sv
// Timer control top: TCR, TSR, PIT (sub-module) and the two-stage watchdog.
// Parameter constraints: TCR_W >= 7, PIT_W <= DW, WD_W >= WD_BASE+12.
// All vectors on the SPR side use big-endian numbering, bit 0 is the MSB.
module p405s_timer_wdog_ctrl
    import p405s_timer_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TCR_W   = 10,
    parameter int PIT_W   = 32,
    parameter int WD_W    = 32,
    parameter int WD_BASE = 8
) (
    input  logic                     CB,
    input  logic                     resetCore,
    p405s_timer_wdog_ctrl_if.slave   sprBus,
    input  logic                     timerTick,
    output logic [0:TCR_W-1]         timerControlL2,
    output logic [0:TSR_W-1]         timerStatusL2,
    output logic [0:PIT_W-1]         pitL2,
    output logic                     pitIrq,
    output logic                     wdIrq,
    output logic [0:1]               wdResetReq
);

    logic             wrEn;
    logic             wrTcr;
    logic             wrTsr;
    logic             wrPit;
    logic [0:TCR_W-1] tcrData;
    logic [0:TCR_W-1] tcrNext;
    logic [0:TSR_W-1] tsrData;
    logic [0:PIT_W-1] pitData;
    logic             pisSet;

    logic [0:1]       tcrWp;
    logic [0:1]       tcrWrc;
    logic [WD_W-1:0]  wdCount;
    logic [WD_W-1:0]  wdMask;
    logic             wdEvt;
    wdState_t         wdState;

    assign wrEn  = sprBus.PCL_mtSPR & ~sprBus.PCL_sprHold;
    assign wrTcr = wrEn & sprBus.tcrDcd;
    assign wrTsr = wrEn & sprBus.tsrDcd;
    assign wrPit = wrEn & sprBus.pitDcd;

    assign tcrData = sprBus.EXE_sprDataBus[0:TCR_W-1];
    assign tsrData = sprBus.EXE_sprDataBus[0:TSR_W-1];
    assign pitData = sprBus.EXE_sprDataBus[DW-PIT_W:DW-1];

    assign tcrWp  = timerControlL2[TCR_WP +: 2];
    assign tcrWrc = timerControlL2[TCR_WRC +: 2];

    // TCR write value: everything loads except WRC, which only accumulates
    always_comb begin
        tcrNext = tcrData;
        tcrNext[TCR_WRC +: 2] = tcrWrc | tcrData[TCR_WRC +: 2];
    end

    // TCR register
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            timerControlL2 <= '0;
        end else if (wrTcr) begin
            timerControlL2 <= tcrNext;
        end
    end

    p405s_pit_dec #(
        .PIT_W (PIT_W)
    ) u_pitDec (
        .CB         (CB),
        .resetCore  (resetCore),
        .wrPit      (wrPit),
        .wrData     (pitData),
        .timerTick  (timerTick),
        .autoReload (timerControlL2[TCR_ARE]),
        .pitCount   (pitL2),
        .pisSet     (pisSet)
    );

    // Watchdog period mask: low WD_BASE+4*WP bits of the free-running counter
    always_comb begin
        wdMask = '0;
        for (int i = 0; i < WD_W; i++) begin
            if (i < wdPeriodBits(WD_BASE, tcrWp)) begin
                wdMask[i] = 1'b1;
            end
        end
    end

    assign wdEvt   = timerTick & ((wdCount & wdMask) == wdMask);
    assign wdState = wdState_t'({timerStatusL2[TSR_ENW], timerStatusL2[TSR_WIS]});

    // Free-running watchdog counter, wraps naturally
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            wdCount <= '0;
        end else if (timerTick) begin
            wdCount <= wdCount + 1'b1;
        end
    end

    // TSR and watchdog FSM; hardware sets are written last so they beat W1C
    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            timerStatusL2 <= '0;
            wdResetReq    <= '0;
        end else begin
            if (wrTsr) begin
                if (tsrData[TSR_ENW]) timerStatusL2[TSR_ENW] <= 1'b0;
                if (tsrData[TSR_WIS]) timerStatusL2[TSR_WIS] <= 1'b0;
                if (tsrData[TSR_PIS]) timerStatusL2[TSR_PIS] <= 1'b0;
            end
            if (pisSet) begin
                timerStatusL2[TSR_PIS] <= 1'b1;
            end
            if (wdEvt) begin
                case (wdState)
                    WD_IDLE: begin
                        timerStatusL2[TSR_ENW] <= 1'b1;
                    end
                    WD_WIS, WD_ENW: begin
                        timerStatusL2[TSR_ENW] <= 1'b1;
                        timerStatusL2[TSR_WIS] <= 1'b1;
                    end
                    WD_EXP: begin
                        timerStatusL2[TSR_ENW] <= 1'b1;
                        timerStatusL2[TSR_WIS] <= 1'b1;
                        if (tcrWrc != 2'b00) begin
                            wdResetReq                 <= tcrWrc;
                            timerStatusL2[TSR_WRS +: 2] <= tcrWrc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pitIrq = timerStatusL2[TSR_PIS] & timerControlL2[TCR_PIE];
    assign wdIrq  = timerStatusL2[TSR_WIS] & timerControlL2[TCR_WIE];

endmodule
